// File: rtl/sys_axi_ar_arbiter_if.sv
// AXI read-address channel bundle shared by the SoC interconnect.
interface sys_axi_ar;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [3:0]  arregion;
  logic        arvalid;
  logic        arready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready
  );
endinterface

// File: rtl/sys_axi_ar_arbiter.sv
// Round-robin arbiter sharing one AXI AR channel among NUM_MASTER requesters,
// with per-master outstanding-read throttling.

// Per-master outstanding-read counter; ok drops once the master hits its limit.
module sys_axi_ar_cnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          ok
);
  // +1 on accepted AR, -1 on completion, both together cancel; floor at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt <= '0;
    else if (inc && !dec)                 cnt <= cnt + CW'(1);
    else if (dec && !inc && cnt != '0)    cnt <= cnt - CW'(1);
  end

  // A completion with nothing outstanding points at a broken R-channel router
  always_ff @(posedge clk) begin
    if (rst_n && dec && !inc)
      assert (cnt != '0) else $warning("r_done seen with no outstanding read");
  end

  assign ok = (cnt < CW'(MAX_OUTSTANDING));
endmodule

module sys_axi_ar_arbiter #(
  parameter int NUM_MASTER      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sys_axi_ar.slave                      s_ar [NUM_MASTER],
  sys_axi_ar.master                     m_ar,
  input  logic [NUM_MASTER-1:0]         r_done,
  output logic [$clog2(NUM_MASTER)-1:0] grant_idx,
  output logic                          busy
);
  localparam int GW = $clog2(NUM_MASTER);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
  } ar_pl_t;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                       state_q, state_d;
  ar_pl_t                       pl [NUM_MASTER];
  ar_pl_t                       sel;
  logic [NUM_MASTER-1:0]        vld, cnt_ok, elig, acc;
  logic [NUM_MASTER-1:0][CW-1:0] out_cnt;
  logic [GW-1:0]                rr_ptr, win_idx;
  logic                         win_vld, hs;

  // Flatten the interface array so the rest can index it with grant_idx
  for (genvar g = 0; g < NUM_MASTER; g++) begin : g_m
    assign vld[g] = s_ar[g].arvalid;
    assign pl[g]  = '{s_ar[g].arid, s_ar[g].araddr, s_ar[g].arlen, s_ar[g].arsize,
                      s_ar[g].arburst, s_ar[g].arlock, s_ar[g].arcache, s_ar[g].arprot,
                      s_ar[g].arqos, s_ar[g].arregion};
    assign s_ar[g].arready = busy && (grant_idx == GW'(g)) && m_ar.arready;
    assign acc[g] = hs && (grant_idx == GW'(g));

    sys_axi_ar_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (acc[g]),
      .dec   (r_done[g]),
      .cnt   (out_cnt[g]),
      .ok    (cnt_ok[g])
    );
  end

  assign elig = vld & cnt_ok;
  assign busy = (state_q == LOCK);
  assign hs   = m_ar.arvalid && m_ar.arready;

  // First eligible index at or after rr_ptr; descending scan so the nearest wins
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = NUM_MASTER-1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_MASTER) j = j - NUM_MASTER;
      if (elig[GW'(j)]) begin
        win_vld = 1'b1;
        win_idx = GW'(j);
      end
    end
  end

  // Grant held until the downstream handshake, then one mandatory idle cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = LOCK;
      LOCK:    if (hs)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, locked index and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_vld) grant_idx <= win_idx;
      if (hs) rr_ptr <= (grant_idx == GW'(NUM_MASTER-1)) ? '0 : grant_idx + GW'(1);
    end
  end

  // Forward the locked master's beat; payload parked at zero when idle
  always_comb begin
    sel = '0;
    if (busy) sel = pl[grant_idx];
  end

  assign m_ar.arvalid  = busy && vld[grant_idx];
  assign m_ar.arid     = sel.id;
  assign m_ar.araddr   = sel.addr;
  assign m_ar.arlen    = sel.len;
  assign m_ar.arsize   = sel.size;
  assign m_ar.arburst  = sel.burst;
  assign m_ar.arlock   = sel.lock;
  assign m_ar.arcache  = sel.cache;
  assign m_ar.arprot   = sel.prot;
  assign m_ar.arqos    = sel.qos;
  assign m_ar.arregion = sel.region;
endmodule
